// File: rtl/aluop_pkg.sv
// Shared definitions for the ALU-op FIFO: class bit positions, 3-bit ALU-op codes,
// encoder result struct and a multi-hot detection helper.
package aluop_pkg;

  localparam int unsigned CLS_W      = 8;
  localparam int unsigned CLS_R      = 0;
  localparam int unsigned CLS_LOAD   = 1;
  localparam int unsigned CLS_STORE  = 2;
  localparam int unsigned CLS_BRANCH = 3;
  localparam int unsigned CLS_I      = 4;
  localparam int unsigned CLS_JALR   = 5;
  localparam int unsigned CLS_JAL    = 6;
  localparam int unsigned CLS_LUI    = 7;

  localparam logic [2:0] ALUOP_R      = 3'b000;
  localparam logic [2:0] ALUOP_LOAD   = 3'b100;
  localparam logic [2:0] ALUOP_STORE  = 3'b101;
  localparam logic [2:0] ALUOP_BRANCH = 3'b010;
  localparam logic [2:0] ALUOP_I      = 3'b001;
  localparam logic [2:0] ALUOP_JALR   = 3'b011;
  localparam logic [2:0] ALUOP_JAL    = 3'b011;
  localparam logic [2:0] ALUOP_LUI    = 3'b110;
  localparam logic [2:0] ALUOP_NONE   = 3'b111;

  typedef struct packed {
    logic [2:0] op;
    logic       multi;
    logic       none;
  } enc_t;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic multi_hot(input logic [CLS_W-1:0] v);
    return |(v & (v - CLS_W'(1)));
  endfunction

endpackage

// File: rtl/aluop_enc.sv
// Combinational priority encoder from instruction-class vector to ALU-op code;
// the lowest set class index wins.
module aluop_enc
  import aluop_pkg::*;
(
  input  logic [CLS_W-1:0] class_i,
  output enc_t             enc_o
);

  // Priority encode the class vector and flag multi-hot / empty vectors.
  always_comb begin
    enc_o.op    = ALUOP_NONE;
    enc_o.multi = multi_hot(class_i);
    enc_o.none  = ~|class_i;
    if (class_i[CLS_R]) begin
      enc_o.op = ALUOP_R;
    end else if (class_i[CLS_LOAD]) begin
      enc_o.op = ALUOP_LOAD;
    end else if (class_i[CLS_STORE]) begin
      enc_o.op = ALUOP_STORE;
    end else if (class_i[CLS_BRANCH]) begin
      enc_o.op = ALUOP_BRANCH;
    end else if (class_i[CLS_I]) begin
      enc_o.op = ALUOP_I;
    end else if (class_i[CLS_JALR]) begin
      enc_o.op = ALUOP_JALR;
    end else if (class_i[CLS_JAL]) begin
      enc_o.op = ALUOP_JAL;
    end else if (class_i[CLS_LUI]) begin
      enc_o.op = ALUOP_LUI;
    end else begin
      enc_o.op = ALUOP_NONE;
    end
  end

endmodule

// File: rtl/aluop_fifo.sv
// Decode-to-execute buffer: encodes each accepted class vector to an ALU-op and
// queues it with its tag; counts accepted no-class instructions (saturating).
module aluop_fifo
  import aluop_pkg::*;
#(
  parameter int unsigned OP_W  = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [CLS_W-1:0] class_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OP_W-1:0]  aluop_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             multi_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic             multi;
  } entry_t;

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic [CNT_W-1:0] illegal_cnt_r;
  enc_t             enc_s;
  entry_t           head_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  aluop_enc u_enc (
    .class_i (class_i),
    .enc_o   (enc_s)
  );

  // Ready/valid come only from the occupancy register, never from out_ready_i.
  assign full_s  = (occ_r == OCC_W'(DEPTH));
  assign empty_s = (occ_r == OCC_W'(0));
  assign push_s  = in_valid_i && !full_s;
  assign pop_s   = out_ready_i && !empty_s;

  // Storage array; reset to zero so the head fields are never X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s && !flush_i) begin
      mem_r[wr_ptr_r] <= '{op: enc_s.op, tag: tag_i, multi: enc_s.multi};
    end
  end

  // Pointer and occupancy bookkeeping; flush discards the cycle's push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      occ_r    <= OCC_W'(0);
    end else if (flush_i) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      occ_r    <= OCC_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Saturating illegal-instruction counter; a flush does not clear it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_cnt_r <= CNT_W'(0);
    end else if (push_s && enc_s.none && (illegal_cnt_r != {CNT_W{1'b1}})) begin
      illegal_cnt_r <= illegal_cnt_r + CNT_W'(1);
    end
  end

  // Present the head entry, zero-extending the 3-bit code to OP_W.
  always_comb begin
    head_s       = mem_r[rd_ptr_r];
    aluop_o      = '0;
    aluop_o[2:0] = head_s.op;
    tag_o        = head_s.tag;
    multi_o      = head_s.multi;
  end

  assign in_ready_o    = !full_s;
  assign out_valid_o   = !empty_s;
  assign illegal_cnt_o = illegal_cnt_r;

endmodule

// File: tb/tb_aluop_fifo.sv
// Directed scoreboard bench for aluop_fifo: a reference encoder and queue model
// predict every head entry, handshake flag and illegal count.
module tb_aluop_fifo;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 5;
  localparam int unsigned CNT_W   = 2;
  localparam int          ILL_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [7:0]       class_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OP_W-1:0]  aluop_o;
  logic [TAG_W-1:0] tag_o;
  logic             multi_o;
  logic [CNT_W-1:0] illegal_cnt_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic             multi;
  } exp_t;

  exp_t sb[$];
  int   exp_ill = 0;

  aluop_fifo #(.OP_W(OP_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .class_i       (class_i),
    .tag_i         (tag_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .aluop_o       (aluop_o),
    .tag_o         (tag_o),
    .multi_o       (multi_o),
    .illegal_cnt_o (illegal_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] c, input logic [TAG_W-1:0] t);
    logic [2:0] tbl [8];
    exp_t e;
    int   n;
    tbl = '{3'b000, 3'b100, 3'b101, 3'b010, 3'b001, 3'b011, 3'b011, 3'b110};
    n       = 0;
    e.op    = 3'b111;
    e.tag   = t;
    for (int i = 7; i >= 0; i--) begin
      if (c[i]) begin
        e.op = tbl[i];
        n++;
      end
    end
    e.multi = (n > 1);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at the falling edge, advance the model, then move past the rising edge.
  task automatic step();
    logic push;
    logic pop;
    exp_t e;
    @(negedge clk);
    chk("in_ready", 32'(in_ready_o), 32'(sb.size() < DEPTH));
    chk("out_valid", 32'(out_valid_o), 32'(sb.size() != 0));
    chk("illegal_cnt", 32'(illegal_cnt_o), 32'(exp_ill));
    if (sb.size() != 0) begin
      chk("head_aluop", 32'(aluop_o), 32'(sb[0].op));
      chk("head_tag", 32'(tag_o), 32'(sb[0].tag));
      chk("head_multi", 32'(multi_o), 32'(sb[0].multi));
    end
    push = in_valid_i && (sb.size() < DEPTH);
    pop  = out_ready_i && (sb.size() != 0);
    if (push && (class_i == 8'h00) && (exp_ill < ILL_MAX)) exp_ill++;
    if (flush_i) begin
      sb.delete();
    end else begin
      if (pop) e = sb.pop_front();
      if (push) sb.push_back(model(class_i, tag_i));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [TAG_W-1:0] t,
                       input logic rdy, input logic fl);
    in_valid_i  = v;
    class_i     = c;
    tag_i       = t;
    out_ready_i = rdy;
    flush_i     = fl;
    step();
  endtask

  // Assert reset asynchronously, check outputs before any clock edge, then release.
  task automatic do_reset(input string name);
    in_valid_i  = 1'b0;
    class_i     = 8'h00;
    tag_i       = '0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    rst_ni      = 1'b0;
    #2;
    chk({name, "_in_ready"}, 32'(in_ready_o), 32'd1);
    chk({name, "_out_valid"}, 32'(out_valid_o), 32'd0);
    chk({name, "_aluop"}, 32'(aluop_o), 32'd0);
    chk({name, "_tag"}, 32'(tag_o), 32'd0);
    chk({name, "_multi"}, 32'(multi_o), 32'd0);
    chk({name, "_illegal_cnt"}, 32'(illegal_cnt_o), 32'd0);
    sb.delete();
    exp_ill = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni      = 1'b1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    class_i     = 8'h00;
    tag_i       = '0;
    out_ready_i = 1'b0;
    #3;
    do_reset("por");

    // First entry, held at the head.
    drive(1'b1, 8'h01, 5'd3, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
    chk("first_aluop", 32'(aluop_o), 32'd0);
    chk("first_tag", 32'(tag_o), 32'd3);

    // Every single class in turn, streaming.
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(1 << i), 5'(10 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 5'd0, 1'b1, 1'b0);

    // Multi-hot vector then three no-class entries.
    drive(1'b1, 8'b0001_0010, 5'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h00, 5'(20 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 5'd0, 1'b1, 1'b0);
    chk("illegal_three", 32'(illegal_cnt_o), 32'd3);

    // Fill past capacity, then stream through the pointer wrap.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h04, 5'(i), 1'b0, 1'b0);
    chk("full_not_ready", 32'(in_ready_o), 32'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(1 << i), 5'(8 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 5'd0, 1'b1, 1'b0);

    // Flush with a no-class push, then with a legal push.
    do_reset("pre_flush");
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h08, 5'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h00, 5'd7, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
    chk("flush_empty", 32'(out_valid_o), 32'd0);
    for (int i = 0; i < 2; i++) drive(1'b1, 8'h10, 5'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h01, 5'd9, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
    chk("flush_keeps_cnt", 32'(illegal_cnt_o), 32'd1);

    // Saturation of the illegal counter.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h00, 5'(i), 1'b1, 1'b0);
    drive(1'b0, 8'h00, 5'd0, 1'b1, 1'b0);
    chk("illegal_sat", 32'(illegal_cnt_o), 32'(ILL_MAX));

    // Asynchronous reset with entries buffered.
    drive(1'b1, 8'h20, 5'd9, 1'b0, 1'b0);
    drive(1'b1, 8'h40, 5'd10, 1'b0, 1'b0);
    do_reset("mid");
    drive(1'b1, 8'h80, 5'd31, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 5'd0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 5'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
